// File: rtl/focus_sweep_ctrl.sv
// focus_sweep_ctrl
// Autofocus search sequencer. On START it runs a coarse sweep of the VCM lens,
// then a fine sweep around the coarse best. At each lens position it takes one
// frame sharpness sample. It finishes by parking the lens at the sharpest
// position found.
//
// Ports
//   VIDEO_CLK  clock, rising edge
//   RESET      asynchronous, active-high reset
//   START      single-cycle search request, ignored while BUSY
//   FRAME_END  single-cycle end-of-frame pulse, SHARP valid with it
//   SHARP      unsigned sharpness sum of the frame just ended
//   VCM_REQ    lens write request, held until VCM_ACK
//   VCM_STEP   lens step code, stable while VCM_REQ
//   VCM_ACK    lens write complete, only honoured while VCM_REQ
//   BUSY       search in progress
//   DONE       one-cycle pulse when the lens is parked at the best position
//   BEST_STEP  best position found so far, final after DONE
//   STATE      current state code (IDLE=0 MOVE=1 SETTLE=2 MEASURE=3 FINAL=4)
module focus_sweep_ctrl #(
    parameter int STEP_W        = 10,
    parameter int SUM_W         = 24,
    parameter int COARSE_STEP   = 32,
    parameter int FINE_STEP     = 4,
    parameter int SETTLE_FRAMES = 2,
    parameter int MAX_STEP      = 1023
) (
    input  logic              VIDEO_CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              FRAME_END,
    input  logic [SUM_W-1:0]  SHARP,
    output logic              VCM_REQ,
    output logic [STEP_W-1:0] VCM_STEP,
    input  logic              VCM_ACK,
    output logic              BUSY,
    output logic              DONE,
    output logic [STEP_W-1:0] BEST_STEP,
    output logic [2:0]        STATE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MOVE    = 3'd1,
        S_SETTLE  = 3'd2,
        S_MEASURE = 3'd3,
        S_FINAL   = 3'd4
    } state_t;

    // Step arithmetic is done two bits wider so pos + increment never wraps.
    localparam int XW = STEP_W + 2;
    localparam logic [XW-1:0] COARSE_X = XW'(COARSE_STEP);
    localparam logic [XW-1:0] FINE_X   = XW'(FINE_STEP);
    localparam logic [XW-1:0] MAX_X    = XW'(MAX_STEP);

    localparam int CNT_W = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);

    state_t            state;
    logic              phase;       // 0 = coarse, 1 = fine
    logic [STEP_W-1:0] pos;
    logic [STEP_W-1:0] hi;          // upper bound of the fine sweep
    logic [STEP_W-1:0] best_step;
    logic [SUM_W-1:0]  best_sum;
    logic [CNT_W-1:0]  settle_cnt;
    logic              vcm_req;
    logic [STEP_W-1:0] vcm_step;
    logic              busy;
    logic              done;

    // Measurement-cycle view of the best position, including the sample that
    // is being taken right now. The fine window is centred on this value.
    logic              better;
    logic [STEP_W-1:0] cand_best;
    logic [XW-1:0]     cand_x;
    logic [XW-1:0]     next_x;
    logic [XW-1:0]     hi_sum;
    logic [STEP_W-1:0] lo_step;
    logic [STEP_W-1:0] hi_step;

    assign better    = SHARP > best_sum;
    assign cand_best = better ? pos : best_step;
    assign cand_x    = {2'b00, cand_best};
    assign next_x    = {2'b00, pos} + (phase ? FINE_X : COARSE_X);
    assign hi_sum    = cand_x + COARSE_X;
    // Lower edge clamps at 0 instead of going negative.
    assign lo_step   = (cand_x < COARSE_X) ? '0 : cand_best - COARSE_X[STEP_W-1:0];
    assign hi_step   = (hi_sum > MAX_X) ? MAX_X[STEP_W-1:0] : hi_sum[STEP_W-1:0];

    always_ff @(posedge VIDEO_CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            phase      <= 1'b0;
            pos        <= '0;
            hi         <= '0;
            best_step  <= '0;
            best_sum   <= '0;
            settle_cnt <= '0;
            vcm_req    <= 1'b0;
            vcm_step   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        pos       <= '0;
                        phase     <= 1'b0;
                        best_sum  <= '0;
                        best_step <= '0;
                        busy      <= 1'b1;
                        vcm_req   <= 1'b1;
                        vcm_step  <= '0;
                        state     <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    // vcm_req is high for the whole of MOVE, so ACK is valid here.
                    if (VCM_ACK) begin
                        vcm_req    <= 1'b0;
                        settle_cnt <= '0;
                        state      <= (SETTLE_FRAMES == 0) ? S_MEASURE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (FRAME_END) begin
                        if (settle_cnt == SETTLE_LAST) state <= S_MEASURE;
                        else settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (FRAME_END) begin
                        if (better) begin
                            best_sum  <= SHARP;
                            best_step <= pos;
                        end
                        if (!phase) begin
                            if (next_x <= MAX_X) begin
                                pos      <= next_x[STEP_W-1:0];
                                vcm_step <= next_x[STEP_W-1:0];
                                vcm_req  <= 1'b1;
                                state    <= S_MOVE;
                            end else begin
                                phase    <= 1'b1;
                                hi       <= hi_step;
                                pos      <= lo_step;
                                vcm_step <= lo_step;
                                vcm_req  <= 1'b1;
                                state    <= S_MOVE;
                            end
                        end else if (next_x <= {2'b00, hi}) begin
                            pos      <= next_x[STEP_W-1:0];
                            vcm_step <= next_x[STEP_W-1:0];
                            vcm_req  <= 1'b1;
                            state    <= S_MOVE;
                        end else begin
                            vcm_step <= cand_best;
                            vcm_req  <= 1'b1;
                            state    <= S_FINAL;
                        end
                    end
                end
                S_FINAL: begin
                    if (VCM_ACK) begin
                        vcm_req <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign VCM_REQ   = vcm_req;
    assign VCM_STEP  = vcm_step;
    assign BUSY      = busy;
    assign DONE      = done;
    assign BEST_STEP = best_step;
    assign STATE     = state;

endmodule

// File: tb/tb_focus_sweep_ctrl.sv
// Bench for focus_sweep_ctrl: full searches from a table of sharpness peaks,
// plus hand-driven sequences for settle counting, handshake and reset.
module tb_focus_sweep_ctrl;

    localparam int STEP_W = 10;
    localparam int SUM_W  = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              fe, ack;
    logic [SUM_W-1:0]  sharp;
    logic              req, busy, done;
    logic [STEP_W-1:0] step, best;
    logic [2:0]        st;

    // auto = responder/frame generator drives; otherwise hand-driven values.
    logic              auto = 1'b0;
    logic              auto_ack = 1'b0, auto_fe = 1'b0;
    logic [SUM_W-1:0]  auto_sharp = '0;
    logic              man_ack = 1'b0, man_fe = 1'b0;
    logic [SUM_W-1:0]  man_sharp = '0;

    assign ack   = auto ? auto_ack : man_ack;
    assign fe    = auto ? auto_fe : man_fe;
    assign sharp = auto ? auto_sharp : man_sharp;

    focus_sweep_ctrl dut (
        .VIDEO_CLK(clk), .RESET(rst), .START(start), .FRAME_END(fe), .SHARP(sharp),
        .VCM_REQ(req), .VCM_STEP(step), .VCM_ACK(ack), .BUSY(busy), .DONE(done),
        .BEST_STEP(best), .STATE(st)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Lens model and sharpness curve.
    int base = 200000;
    int peak = 330;
    int lens = 0;
    int writes[$];
    int wait_cnt = 0, frame_div = 0;
    int done_cnt = 0, done_busy_bad = 0, stable_bad = 0;
    logic              prev_req = 1'b0, last_acc = 1'b0;
    logic [STEP_W-1:0] prev_step = '0;

    function automatic logic [SUM_W-1:0] sharp_of(input int p);
        int d;
        d = p - peak;
        if (d < 0) d = -d;
        return SUM_W'(base - 100 * d);
    endfunction

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (busy) done_busy_bad++;
        end
        if (req && prev_req && step != prev_step) stable_bad++;
        if (last_acc && req) stable_bad++;   // REQ must not re-assert right after ACK
        prev_req  = req;
        prev_step = step;
        auto_ack  = 1'b0;
        auto_fe   = 1'b0;
        if (auto) begin
            if (req) begin
                wait_cnt++;
                if (wait_cnt == 5) begin
                    auto_ack = 1'b1;
                    wait_cnt = 0;
                    writes.push_back(int'(step));
                    lens = int'(step);
                end
            end else wait_cnt = 0;
            frame_div++;
            if (frame_div == 8) begin
                frame_div  = 0;
                auto_fe    = 1'b1;
                auto_sharp = sharp_of(lens);
            end
        end
        last_acc = auto && auto_ack;
    end

    typedef struct {
        int base;
        int peak;
        int exp_best;
        int lo;
        int last;
    } vec_t;

    vec_t tbl[4];

    task automatic run_search(input vec_t v, input string tag);
        int w0, d0, s0, n, bad;
        int exp_w[$];
        base = v.base;
        peak = v.peak;
        w0 = writes.size();
        d0 = done_cnt;
        s0 = stable_bad;
        auto = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_req_rise"}, int'(req), 1);
        check({tag, "_busy_set"}, int'(busy), 1);
        n = 0;
        while (done_cnt == d0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_in_budget"}, int'(n < 8000), 1);
        repeat (3) @(negedge clk);
        for (int p = 0; p <= 992; p += 32) exp_w.push_back(p);
        for (int p = v.lo; p <= v.last; p += 4) exp_w.push_back(p);
        exp_w.push_back(v.exp_best);
        check({tag, "_nwrites"}, writes.size() - w0, exp_w.size());
        bad = 0;
        for (int i = 0; i < exp_w.size(); i++)
            if (w0 + i >= writes.size() || writes[w0 + i] != exp_w[i]) bad++;
        check({tag, "_write_seq_mismatches"}, bad, 0);
        check({tag, "_best_step"}, int'(best), v.exp_best);
        check({tag, "_step_hold"}, int'(step), v.exp_best);
        check({tag, "_busy_clr"}, int'(busy), 0);
        check({tag, "_state_idle"}, int'(st), 0);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_req_stable_errs"}, stable_bad - s0, 0);
        auto = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},  int'(req),  0);
        check({tag, "_step"}, int'(step), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_best"}, int'(best), 0);
        check({tag, "_state"}, int'(st), 0);
    endtask

    task automatic man_frame(input logic [SUM_W-1:0] s);
        @(negedge clk) begin man_fe = 1'b1; man_sharp = s; end
        @(negedge clk) man_fe = 1'b0;
    endtask

    initial begin
        int n, bad;
        tbl[0] = '{100000, 330, 328, 288, 352};   // nominal, tie 328/332
        tbl[1] = '{200000, 0, 0, 0, 32};          // lower clamp
        tbl[2] = '{200000, 1000, 1000, 960, 1020}; // upper clamp
        tbl[3] = '{150000, 900, 900, 864, 928};   // run after mid-search reset

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        // START held across reset release must not launch a search.
        start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("start_at_reset_release", int'(st), 0);
        check("no_req_after_release", int'(req), 0);

        for (int i = 0; i < 3; i++) run_search(tbl[i], $sformatf("vec%0d", i));

        // Settle counting with frames coincident with ACK and bogus maxima.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("man_move0", int'(st), 1);
        repeat (2) @(negedge clk);
        man_ack = 1'b1; man_fe = 1'b1; man_sharp = '1;
        @(negedge clk) begin man_ack = 1'b0; man_fe = 1'b0; end
        check("settle_entered", int'(st), 2);
        check("req_dropped", int'(req), 0);
        @(negedge clk) man_ack = 1'b1;        // ACK while REQ low
        @(negedge clk) man_ack = 1'b0;
        check("ack_noreq_state", int'(st), 2);
        check("ack_noreq_req", int'(req), 0);
        man_frame('1);
        check("settle_frame1", int'(st), 2);
        man_frame('1);
        check("settle_frame2_measure", int'(st), 3);
        man_frame(24'd5);
        check("measured_move", int'(st), 1);
        check("next_pos32", int'(step), 32);
        repeat (2) @(negedge clk);
        man_ack = 1'b1; man_fe = 1'b1; man_sharp = '1;
        @(negedge clk) begin man_ack = 1'b0; man_fe = 1'b0; end
        man_frame('1);
        man_frame('1);
        check("pt2_measure", int'(st), 3);
        man_frame(24'd1);
        check("pt2_best_kept", int'(best), 0);
        check("next_pos64", int'(step), 64);
        // START while busy, then ACK held low for a long time.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (req !== 1'b1 || step !== 10'd64 || st !== 3'd1 || busy !== 1'b1) bad++;
        end
        check("ack_hold_stable_errs", bad, 0);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst_a");
        @(negedge clk) rst = 1'b0;

        // Reset during SETTLE of the 5th coarse point, then a fresh search.
        base = 200000;
        peak = 330;
        auto = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(writes.size() > 0 && writes[writes.size() - 1] == 128 && st == 3'd2) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("reach_5th_settle", int'(n < 4000), 1);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst_b");
        auto = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        run_search(tbl[3], "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/focus_sweep_ctrl.md
# focus_sweep_ctrl

Frame-level autofocus search sequencer for the D8M camera path. On a start pulse it steps the VCM lens position through a coarse sweep and then a fine sweep, capturing the per-frame sharpness sum at each position. It then parks the lens at the sharpest position found. It sits between the pixel sharpness accumulator (SHARP/FRAME_END) and the VCM I2C writer (VCM_REQ/VCM_STEP/VCM_ACK), replacing free-running step generation with a deterministic, handshaked search.

## Interface
Parameters:
- STEP_W, 10, width of VCM step code
- SUM_W, 24, width of frame sharpness sum
- COARSE_STEP, 32, coarse sweep increment
- FINE_STEP, 4, fine sweep increment
- SETTLE_FRAMES, 2, frames discarded after each lens move
- MAX_STEP, 1023, highest legal step code

Ports:
- VIDEO_CLK  in  1  sole clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  single-cycle request to begin a search; ignored while BUSY=1
- FRAME_END  in  1  single-cycle pulse; SHARP is valid in the same cycle
- SHARP  in  SUM_W  sharpness sum of the frame just ended, unsigned
- VCM_REQ  out  1  write request to the VCM I2C writer
- VCM_STEP  out  STEP_W  step code to write; stable while VCM_REQ=1
- VCM_ACK  in  1  writer has completed the write; sampled only while VCM_REQ=1
- BUSY  out  1  search in progress
- DONE  out  1  single-cycle pulse when the lens is parked at the best position
- BEST_STEP  out  STEP_W  best position found; final after DONE
- STATE  out  3  current state code, for the STATUS LEDs

## Operation
- States and codes: IDLE=0, MOVE=1, SETTLE=2, MEASURE=3, FINAL=4. A separate PHASE bit selects coarse (0) or fine (1).
- IDLE -> MOVE on START. Actions on this transition:
  - pos=0, PHASE=0, best_sum=0, BEST_STEP=0, BUSY=1.
- MOVE: VCM_REQ=1, VCM_STEP=pos.
  - On a cycle with VCM_ACK=1: VCM_REQ=0 on the next cycle, settle counter cleared, go to SETTLE.
- SETTLE: counts FRAME_END pulses.
  - A FRAME_END coincident with the accepting VCM_ACK cycle is not counted.
  - After SETTLE_FRAMES pulses, go to MEASURE.
  - If SETTLE_FRAMES=0, go straight to MEASURE.
- MEASURE: on the next FRAME_END, compare SHARP to best_sum.
  - If SHARP > best_sum (strict), load best_sum=SHARP and BEST_STEP=pos. Ties keep the earlier position.
  - Then compute next = pos + increment, where increment is COARSE_STEP in coarse phase and FINE_STEP in fine phase. Compute in STEP_W+2 bits; no wrap.
- Coarse phase, next <= MAX_STEP: pos=next, go to MOVE.
- Coarse phase, next > MAX_STEP: enter fine phase.
  - PHASE=1.
  - lo = max(BEST_STEP - COARSE_STEP, 0). Compute signed; clamp at 0.
  - hi = min(BEST_STEP + COARSE_STEP, MAX_STEP).
  - pos=lo, go to MOVE.
- Fine phase, next <= hi: pos=next, go to MOVE.
- Fine phase, next > hi: go to FINAL.
- FINAL: lens write of BEST_STEP.
  - VCM_REQ=1, VCM_STEP=BEST_STEP.
  - On VCM_ACK: VCM_REQ=0, DONE=1 for one cycle, BUSY=0, go to IDLE.
- BEST_STEP and VCM_STEP hold their values in IDLE until the next START.
- The fine sweep revisits the coarse best position. Its new measurement replaces best only if it is strictly greater.

## Timing
- Reset values: VCM_REQ=0, VCM_STEP=0, BUSY=0, DONE=0, BEST_STEP=0, STATE=0, PHASE=0. RESET mid-search aborts immediately (asynchronous); a REQ in flight is dropped.
- START to VCM_REQ rising: 1 cycle.
- VCM_ACK edge to VCM_REQ low: 1 cycle. VCM_REQ never re-asserts in the cycle after ACK.
- ACK while VCM_REQ=0 is ignored. FRAME_END in MOVE or FINAL is ignored.
- Registered outputs only; DONE and the BUSY fall occur in the same cycle.
- START coincident with RESET deassertion is ignored. START in the cycle DONE pulses is ignored (BUSY still 1 at the sampling edge).
- Measurement uses the (SETTLE_FRAMES+1)-th FRAME_END after the accepting ACK.

## Test plan
- Nominal search. Setup: defaults; ACK 5 cycles after each REQ; SHARP = 100000 - 100*|pos-330|.
  - Coarse visits 0,32,...,992 (32 writes) and picks best 320.
  - Fine visits 288..352 step 4 (17 writes).
  - Final write 328 (tie 328/332 keeps 328); DONE pulses once; BEST_STEP=328.
- Lower-clamp boundary. Setup: SHARP peak at pos=0.
  - Fine range is 0..32; final VCM_STEP=0.
- Upper-clamp boundary. Setup: SHARP peak at 1000.
  - Coarse best is 992; fine range 960..1020 (1024 exceeds hi=1023).
  - Final is 1000.
- Settle counting. Setup: SETTLE_FRAMES=2; FRAME_END coincident with ACK.
  - SHARP is captured on the 3rd later FRAME_END, not the 2nd.
  - Frames injected with SHARP=max during settle must not change BEST_STEP.
- Handshake and START robustness. Setup: hold ACK low for 1000 cycles; pulse START while BUSY.
  - VCM_REQ and VCM_STEP stay stable; the search does not restart.
  - ACK with REQ=0 causes no state change.
- Reset mid-operation. Setup: assert RESET during SETTLE of the 5th coarse point.
  - All outputs return to reset values within the same cycle, without a clock edge.
  - A new START then begins at pos=0 with best_sum=0.
